// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl; the requester is the master.
// The sub select exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output start, a, b,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  start, a, b,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice (two halfAdders + OR), LSB first, WIDTH+2 cycles per op.
// Latency: done/sum/cout after edge WIDTH; start ignored while busy. SERIAL_ADDER_SUB_EN adds A-B.
module halfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_ctrl_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sha, shb, psum, sum_q;
  logic [CW-1:0]    cnt;
  logic             carry, cout_q;
  logic             s0, c0, s1, c1, c_next;
  logic             last;

  halfAdder u_ha0 (.a(sha[0]), .b(shb[0]), .s(s0), .c(c0));
  halfAdder u_ha1 (.a(s0),     .b(carry),  .s(s1), .c(c1));
  assign c_next = c0 | c1;

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sha    <= '0;
      shb    <= '0;
      psum   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (state == IDLE) begin
      if (bus.start) begin
        sha <= bus.a;
        cnt <= '0;
`ifdef SERIAL_ADDER_SUB_EN
        // Two's-complement subtract: invert B and inject the +1 through the carry
        shb   <= bus.sub ? ~bus.b : bus.b;
        carry <= bus.sub;
`else
        shb   <= bus.b;
        carry <= 1'b0;
`endif
      end
    end else if (state == RUN) begin
      sha   <= sha >> 1;
      shb   <= shb >> 1;
      carry <= c_next;
      cnt   <= cnt + CW'(1);
      psum  <= {s1, psum[WIDTH-1:1]};
      if (last) begin
        sum_q  <= {s1, psum[WIDTH-1:1]};
        cout_q <= c_next;
      end
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scenario bench for serial_adder_ctrl (WIDTH=8): expected {cout,sum} queued at start, popped at done.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [W:0] exp_q[$];

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();
  serial_adder_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for IDLE, presents operands for one accepting edge, then scrambles them.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sb);
    logic [W:0] e;
    bit idle;
    idle = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        idle = 1;
        break;
      end
    end
    tests++;
    if (!idle) begin
      fails++;
      $display("FAIL start_op_idle: busy stuck at %0b, required 0", bus.busy);
    end
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = sb;
`endif
    if (sb) e = {1'b0, av} + {1'b0, ~bv} + 9'd1;
    else    e = {1'b0, av} + {1'b0, bv};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = ~sb;
`endif
  endtask

  task automatic wait_done(output int lat, output bit seen);
    lat  = 0;
    seen = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat  = i;
        seen = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests += 4;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin fails++; $display("FAIL rst_done: got %0b want 0", bus.done); end
    if (bus.sum !== 8'h00) begin fails++; $display("FAIL rst_sum: got %02h want 00", bus.sum); end
    if (bus.cout !== 1'b0) begin fails++; $display("FAIL rst_cout: got %0b want 0", bus.cout); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests += 2;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL post_rst_busy: got %0b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin fails++; $display("FAIL post_rst_done: got %0b want 0", bus.done); end
  endtask

  task automatic test_basic();
    int busy_cnt, done_cnt, lat;
    logic [W:0] e, got;
    got = '0;
    lat = 0;
    done_cnt = 0;
    start_op(8'h5A, 8'h33, 1'b0);
    busy_cnt = bus.busy ? 1 : 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (lat == 0) begin lat = i; got = {bus.cout, bus.sum}; end
      end
      if (!bus.busy) break;
    end
    e = exp_q.pop_front();
    tests += 5;
    if (lat != 8) begin fails++; $display("FAIL basic_latency: got %0d want 8", lat); end
    if (busy_cnt != 9) begin fails++; $display("FAIL basic_busy_cycles: got %0d want 9", busy_cnt); end
    if (done_cnt != 1) begin fails++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
    if (got[W-1:0] !== e[W-1:0]) begin fails++; $display("FAIL basic_sum: got %02h want %02h", got[W-1:0], e[W-1:0]); end
    if (got[W] !== e[W]) begin fails++; $display("FAIL basic_cout: got %0b want %0b", got[W], e[W]); end
  endtask

  task automatic test_carry_clear();
    logic [W-1:0] av[2];
    logic [W-1:0] bv[2];
    logic [W:0] e;
    int lat;
    bit seen;
    av[0] = 8'hFF; bv[0] = 8'h01;
    av[1] = 8'h00; bv[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      start_op(av[k], bv[k], 1'b0);
      wait_done(lat, seen);
      e = exp_q.pop_front();
      tests += 3;
      if (!seen) begin fails++; $display("FAIL carry_done_%0d: no done within bound", k); end
      if (bus.sum !== e[W-1:0]) begin fails++; $display("FAIL carry_sum_%0d: got %02h want %02h", k, bus.sum, e[W-1:0]); end
      if (bus.cout !== e[W]) begin fails++; $display("FAIL carry_cout_%0d: got %0b want %0b", k, bus.cout, e[W]); end
    end
  endtask

  task automatic test_ignore_start();
    int done_cnt;
    logic [W:0] e;
    done_cnt = 0;
    start_op(8'h12, 8'h34, 1'b0);
    e = exp_q.pop_front();
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        done_cnt++;
        tests += 2;
        if (bus.sum !== e[W-1:0]) begin fails++; $display("FAIL ignore_sum: got %02h want %02h", bus.sum, e[W-1:0]); end
        if (bus.cout !== e[W]) begin fails++; $display("FAIL ignore_cout: got %0b want %0b", bus.cout, e[W]); end
      end
      if (c == 2 || c == 8) begin bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF; end
      if (c == 3 || c == 9) bus.start = 1'b0;
    end
    tests += 2;
    if (done_cnt != 1) begin fails++; $display("FAIL ignore_done_pulses: got %0d want 1", done_cnt); end
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL ignore_requeued: busy %0b want 0", bus.busy); end
  endtask

  task automatic test_reset_midrun();
    int lat;
    bit seen;
    logic [W:0] e;
    start_op(8'hAA, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests += 4;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %0b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin fails++; $display("FAIL midrst_done: got %0b want 0", bus.done); end
    if (bus.sum !== 8'h00) begin fails++; $display("FAIL midrst_sum: got %02h want 00", bus.sum); end
    if (bus.cout !== 1'b0) begin fails++; $display("FAIL midrst_cout: got %0b want 0", bus.cout); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    start_op(8'h01, 8'h02, 1'b0);
    wait_done(lat, seen);
    e = exp_q.pop_front();
    tests += 3;
    if (!seen || lat != 8) begin fails++; $display("FAIL midrst_latency: got %0d want 8", lat); end
    if (bus.sum !== e[W-1:0]) begin fails++; $display("FAIL midrst_sum2: got %02h want %02h", bus.sum, e[W-1:0]); end
    if (bus.cout !== e[W]) begin fails++; $display("FAIL midrst_cout2: got %0b want %0b", bus.cout, e[W]); end
  endtask

  task automatic test_back_to_back();
    int rises, dones, last_rise;
    logic prev;
    logic [W:0] e;
    rises = 0; dones = 0; last_rise = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    prev = bus.busy;
    bus.start = 1'b1;
    bus.a = 8'h10;
    bus.b = 8'h20;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.busy && !prev) begin
        rises++;
        exp_q.push_back({1'b0, bus.a} + {1'b0, bus.b});
        if (rises > 1) begin
          tests++;
          if (c - last_rise != 10) begin fails++; $display("FAIL b2b_interval: got %0d want 10", c - last_rise); end
        end
        last_rise = c;
        if (rises == 4) bus.start = 1'b0;
      end
      if (bus.done) begin
        dones++;
        tests += 3;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL b2b_unexpected_done: queue empty at cycle %0d", c);
        end else begin
          e = exp_q.pop_front();
          if (e !== 9'h030) begin fails++; $display("FAIL b2b_expected: got %03h want 030", e); end
          if (bus.sum !== e[W-1:0]) begin fails++; $display("FAIL b2b_sum: got %02h want %02h", bus.sum, e[W-1:0]); end
          if (bus.cout !== e[W]) begin fails++; $display("FAIL b2b_cout: got %0b want %0b", bus.cout, e[W]); end
        end
      end
      prev = bus.busy;
    end
    tests += 2;
    if (rises != 4) begin fails++; $display("FAIL b2b_accepts: got %0d want 4", rises); end
    if (dones != 4) begin fails++; $display("FAIL b2b_dones: got %0d want 4", dones); end
    bus.start = 1'b0;
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [W-1:0] av[2];
    logic [W-1:0] bv[2];
    logic [W:0] e;
    int lat;
    bit seen;
    av[0] = 8'h10; bv[0] = 8'h01;
    av[1] = 8'h01; bv[1] = 8'h02;
    for (int k = 0; k < 2; k++) begin
      start_op(av[k], bv[k], 1'b1);
      wait_done(lat, seen);
      e = exp_q.pop_front();
      tests += 3;
      if (!seen) begin fails++; $display("FAIL sub_done_%0d: no done within bound", k); end
      if (bus.sum !== e[W-1:0]) begin fails++; $display("FAIL sub_sum_%0d: got %02h want %02h", k, bus.sum, e[W-1:0]); end
      if (bus.cout !== e[W]) begin fails++; $display("FAIL sub_cout_%0d: got %0b want %0b", k, bus.cout, e[W]); end
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_carry_clear();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition sequencer built around the team's `halfAdder` gate-level cell. It accepts two WIDTH-bit operands through a start/done handshake. It then adds them LSB-first, one bit per clock, through a single full-adder slice made of two `halfAdder` instances and an OR gate. Its purpose is a minimum-area adder for control-path arithmetic where latency is not critical.

## Interface
- `WIDTH`, default 8: operand and result width, legal range 2–32.
- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request an operation. Sampled only in IDLE.
- `a` input WIDTH: augend. Captured on the accepting edge.
- `b` input WIDTH: addend. Captured on the accepting edge.
- `busy` output 1: high while an operation is in progress (RUN or DONE).
- `done` output 1: single-cycle completion pulse.
- `sum` output WIDTH: registered result, held until the next completion.
- `cout` output 1: registered carry-out of the MSB, held with `sum`.
- `sub` input 1: subtract select. Present only when `SERIAL_ADDER_SUB_EN` is defined (see Configuration).

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- IDLE, `start`=1 at an edge:
  - load shift register A←`a` and shift register B←`b`;
  - clear the carry flop;
  - clear bit counter `cnt`;
  - go to RUN.
- IDLE, `start`=0: remain in IDLE.
- RUN, each edge:
  - the slice computes s = A[0]^B[0]^c and c' = A[0]&B[0] | (A[0]^B[0])&c;
  - s shifts into the MSB of the partial-sum register; A and B shift right by one;
  - carry ← c';
  - `cnt` increments.
- RUN exit: on the edge where `cnt`==WIDTH-1 (the last bit), go to DONE. On that same edge, `sum`←the final partial sum including this bit, and `cout`←c'.
- DONE: lasts exactly one cycle, then IDLE unconditionally.
- `busy` = (state != IDLE). `done` = (state == DONE). Both are decoded from registered state only.
- `start` asserted in RUN or DONE is ignored. It is not queued. The requester must hold `start` until it sees `busy`=1, or re-assert it after `done`.
- `a`, `b` and `sub` may change freely after the accepting edge; they have no effect on the operation in flight.
- `sum`/`cout` change only on the RUN→DONE edge. Partial results are never visible on the outputs.
- Arithmetic is modulo 2^WIDTH. `cout` is the unsigned carry. There is no signed overflow flag.
- `cnt` width is clog2(WIDTH). The counter does not wrap within an operation.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, carry=0, `cnt`=0.
- Reset acts immediately, including mid-RUN. The in-flight operation is discarded, and outputs return to reset values without waiting for a clock.
- Latency, with the accepting edge as edge 0:
  - `busy` rises after edge 0;
  - `sum`/`cout` are valid and `done`=1 after edge WIDTH;
  - `busy`/`done` fall after edge WIDTH+1.
- Throughput: a new `start` can be accepted at edge WIDTH+2 at the earliest. Back-to-back operations therefore take WIDTH+2 cycles each.
- `done` is high for exactly one cycle per accepted `start`.

## Configuration
- `SERIAL_ADDER_SUB_EN` undefined:
  - no `sub` port;
  - addition only;
  - carry clears to 0 on start.
- `SERIAL_ADDER_SUB_EN` defined:
  - the `sub` port exists and is captured with the operands on the accepting edge;
  - when captured `sub`=1, B loads ~`b` and carry loads 1, giving A−B;
  - `cout`=1 means no borrow (a ≥ b unsigned);
  - `sub`=0 behaves exactly as the undefined build.

## Test plan
All scenarios use WIDTH=8.
- Reset, then `a`=0x5A, `b`=0x33, `start` pulse → `done` exactly 8 cycles after the accepting edge, `sum`=0x8D, `cout`=0, `busy` high for 9 cycles.
- `a`=0xFF, `b`=0x01 → `sum`=0x00, `cout`=1. Then `a`=0x00, `b`=0x00 → `sum`=0x00, `cout`=0, proving the carry clears between operations.
- Start 0x12+0x34, then pulse `start` with 0xFF+0xFF at cycles 3 and 9 (in RUN and DONE) → ignored, single `done`, `sum`=0x46, `cout`=0.
- Start 0xAA+0x55, assert `rst` at cycle 4 → `busy`/`done`/`sum`/`cout` go to 0 immediately. A subsequent 0x01+0x02 gives `sum`=0x03 with full 8-cycle latency.
- `start` held high continuously with 0x10+0x20 → an operation is accepted every 10 cycles; every `done` shows `sum`=0x30.
- With `SERIAL_ADDER_SUB_EN`: `sub`=1, 0x10−0x01 → `sum`=0x0F, `cout`=1. Then 0x01−0x02 → `sum`=0xFF, `cout`=0.
